// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed register file.
// Inserts WAIT_CYCLES wait states per access and flags misaligned or out-of-range accesses.
module apb_slave_mem #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int unsigned IdxW  = ADDR_WIDTH - 2;
    localparam int unsigned MemAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [MemAw-1:0]      widx_q, widx_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [IdxW-1:0]  idx;
    logic [MemAw-1:0] mem_idx;
    logic             addr_err;
    logic             mem_we;

    assign idx      = PADDR[ADDR_WIDTH-1:2];
    assign mem_idx  = idx[MemAw-1:0];
    assign addr_err = (PADDR[1:0] != 2'b00) || (32'(idx) >= DEPTH);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        widx_d    = widx_q;
        write_d   = write_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        mem_we    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (PSEL && !PENABLE) begin
                    widx_d  = mem_idx;
                    write_d = PWRITE;
                    err_d   = addr_err;
                    wdata_d = PWDATA;
                    if (WAIT_CYCLES == 0) begin
                        // Zero-wait: the response is formed straight from the live bus.
                        state_d   = StDone;
                        pready_d  = 1'b1;
                        pslverr_d = addr_err;
                        prdata_d  = (PWRITE || addr_err) ? '0 : mem_q[mem_idx];
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            StWait: begin
                if (!PSEL) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (PENABLE) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d   = StDone;
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        prdata_d  = (write_q || err_q) ? '0 : mem_q[widx_q];
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                mem_we  = PSEL && write_q && !err_q;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            widx_q    <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            widx_q    <= widx_d;
            write_q   <= write_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            mem_q <= '{default: '0};
        end else if (mem_we) begin
            mem_q[widx_q] <= wdata_q;
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB3 completer (slave) with a word-addressed register-file memory.
- Sits directly downstream of the APB master VIP on apb_intf and responds to its transfers.
- Parameterised wait-state insertion exercises the master's PREADY handling.
- PSLVERR is returned for out-of-range or misaligned accesses so the master's error path is covered.

Parameters:
- ADDR_WIDTH, 8, PADDR width in bits.
- DATA_WIDTH, 32, PWDATA/PRDATA width in bits.
- DEPTH, 32, number of DATA_WIDTH-bit words. Must satisfy DEPTH <= 2^(ADDR_WIDTH-2).
- WAIT_CYCLES, 1, number of access-phase cycles with PREADY=0 before PREADY=1. Range 0..15.

Ports:
- PCLK, in, 1: single clock. All logic is on the rising edge.
- PRESET, in, 1: reset, synchronous, active-high.
- PSEL, in, 1: slave select.
- PENABLE, in, 1: access-phase indicator.
- PWRITE, in, 1: 1 = write, 0 = read.
- PADDR, in, ADDR_WIDTH: byte address.
- PWDATA, in, DATA_WIDTH: write data.
- PREADY, out, 1: transfer completion (registered).
- PRDATA, out, DATA_WIDTH: read data (registered).
- PSLVERR, out, 1: error response, valid only while PREADY=1 (registered).

Behaviour:
- Reset (PRESET=1 at a PCLK edge), including mid-transfer:
  - state=IDLE, wait counter=0, PREADY=0, PRDATA=0, PSLVERR=0.
  - All memory words are cleared to 0.
  - Any in-flight transfer is dropped with no write.
- Address decode:
  - Word index = PADDR[ADDR_WIDTH-1:2].
  - Error if PADDR[1:0]!=0 or word index >= DEPTH.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On a setup cycle (PSEL=1, PENABLE=0): latch PADDR, PWRITE, PWDATA and the error flag.
  - If WAIT_CYCLES=0: go to DONE. PREADY, PSLVERR and PRDATA are set at this same edge.
  - Otherwise: wait counter = WAIT_CYCLES, go to WAIT, PREADY stays 0.
  - PSEL=0 or PENABLE=1 in IDLE: no action.
- WAIT:
  - Each cycle with PSEL=1 and PENABLE=1, decrement the counter.
  - At the edge where the counter goes 1->0: go to DONE and set PREADY=1.
  - At that same edge:
    - PSLVERR = error flag.
    - PRDATA = mem[index] for a valid read, 0 for a write or error.
- Total access-phase length is WAIT_CYCLES+1 cycles. PREADY is high in exactly the last one.
- DONE (PREADY=1):
  - At this edge, a valid write with no error stores the latched PWDATA into mem[index]. Error writes leave memory unchanged.
  - PREADY, PSLVERR and PRDATA return to 0 and the state returns to IDLE.
- Back-to-back transfers:
  - A setup cycle immediately following the DONE cycle is accepted from IDLE with no idle gap.
  - Read-after-write to the same address returns the new data.
- Protocol violation: PSEL=0 while in WAIT or DONE aborts to IDLE. No write, outputs go to 0.
- Input changes during WAIT are ignored because the values were latched at setup.
- Simultaneous reset and setup: reset wins.

Test Plan:
- Reset check: hold PRESET=1 for 2 cycles with PSEL=1 -> PREADY=0, PRDATA=0, PSLVERR=0. Subsequent reads of addresses 0x00..0x7C return 0.
- WAIT_CYCLES=1: write 0xDEADBEEF to 0x04, then read 0x04.
  - Each access phase shows PREADY=0 for 1 cycle, then PREADY=1 for 1 cycle.
  - Read returns PRDATA=0xDEADBEEF with PSLVERR=0.
- Error cases:
  - Write 0x12345678 to 0x80 (index 32 >= DEPTH) -> PSLVERR=1 with PREADY. A read of 0x00 shows it unchanged.
  - Read 0x06 (misaligned) -> PSLVERR=1, PRDATA=0.
- WAIT_CYCLES=0, back-to-back:
  - Writes 0x11 to 0x08 and 0x22 to 0x0C, then reads of both, with no idle cycles between transfers.
  - Each transfer takes 2 cycles.
  - Reads return 0x11 then 0x22.
- WAIT_CYCLES=3: read 0x04 -> PREADY low for 3 access cycles, high on the 4th.
- Mid-transfer reset:
  - Write 0xAAAA to 0x10 and assert PRESET during WAIT.
  - Expect no write, PREADY=0 on the next cycle, and a later read of 0x10 returning 0.
- Aborted transfer: drop PSEL during WAIT of a write of 0x55 to 0x14 -> FSM returns to IDLE and a later read of 0x14 returns 0.
